// File: rtl/div_sequencer.sv
// Divider front-end: special cases and cache hits answer in the cycle after req, else the divider is launched and resp follows div_resp by one cycle.
// stall holds the pipeline while req is pending; flush kills the op, and a launched divide is drained before any relaunch.
module div_sequencer #(
    parameter int XLEN     = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            stall,
    output logic            resp,
    output logic [XLEN-1:0] result,
    output logic            div_enable,
    output logic [2:0]      div_funct3,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic [XLEN-1:0] div_f,
    input  logic            div_resp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    logic            resp_q;
    logic [XLEN-1:0] result_q;
    logic            en_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;

    logic            cache_vld_q;
    logic [2:0]      cache_f3_q;
    logic [XLEN-1:0] cache_a_q;
    logic [XLEN-1:0] cache_b_q;
    logic [XLEN-1:0] cache_dat_q;

    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res_d;
    logic            cache_hit;
    logic            accept;

    // funct3[0] = unsigned, funct3[1] = remainder
    always_comb begin
        b_zero        = (req_b == '0);
        ovf           = !req_funct3[0] && (req_a == INT_MIN) && (req_b == '1);
        special       = b_zero || ovf;
        special_res_d = '0;
        if (b_zero) begin
            special_res_d = req_funct3[1] ? req_a : '1;
        end else if (ovf) begin
            special_res_d = req_funct3[1] ? '0 : INT_MIN;
        end
        cache_hit = CACHE_EN && cache_vld_q && (cache_f3_q == req_funct3)
                    && (cache_a_q == req_a) && (cache_b_q == req_b);
        accept    = req && !flush && req_funct3[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            resp_q      <= 1'b0;
            result_q    <= '0;
            en_q        <= 1'b0;
            f3_q        <= 3'b100;
            a_q         <= '0;
            b_q         <= '0;
            cache_vld_q <= 1'b0;
            cache_f3_q  <= 3'b100;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_dat_q <= '0;
        end else begin
            en_q   <= 1'b0;
            resp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (special) begin
                            result_q <= special_res_d;
                            resp_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (cache_hit) begin
                            result_q <= cache_dat_q;
                            resp_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            f3_q    <= req_funct3;
                            a_q     <= req_a;
                            b_q     <= req_b;
                            en_q    <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (div_resp) begin
                        // The divide finished, so the cache keeps it even when flushed.
                        if (CACHE_EN) begin
                            cache_vld_q <= 1'b1;
                            cache_f3_q  <= f3_q;
                            cache_a_q   <= a_q;
                            cache_b_q   <= b_q;
                            cache_dat_q <= div_f;
                        end
                        if (flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            result_q <= div_f;
                            resp_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (div_resp) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp       = resp_q && !flush;
    assign stall      = req && !resp;
    assign result     = result_q;
    assign div_enable = en_q;
    assign div_funct3 = f3_q;
    assign div_a      = a_q;
    assign div_b      = b_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed plus random bench for div_sequencer with a behavioural divider and RISC-V arithmetic reference.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  req_funct3;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        stall;
    logic        resp;
    logic [31:0] result;
    logic        div_enable;
    logic [2:0]  div_funct3;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_f;
    logic        div_resp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_edge = 0;
    int div_lat = 34;

    bit          cv = 1'b0;
    logic [2:0]  cf3;
    logic [31:0] ca;
    logic [31:0] cb;

    div_sequencer #(.XLEN(32), .CACHE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_funct3(req_funct3),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
        .resp(resp), .result(result), .div_enable(div_enable),
        .div_funct3(div_funct3), .div_a(div_a), .div_b(div_b),
        .div_f(div_f), .div_resp(div_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural divider: result div_lat cycles after the launch, flags relaunch while busy.
    initial begin
        logic [2:0]  f3c;
        logic [31:0] ac;
        logic [31:0] bc;
        int          l;
        div_resp = 1'b0;
        div_f    = '0;
        forever begin
            @(posedge clk); #1;
            if (div_enable === 1'b1) begin
                f3c = div_funct3;
                ac  = div_a;
                bc  = div_b;
                l   = div_lat;
                repeat (l - 1) begin
                    @(posedge clk); #1;
                    check("no_relaunch", 32'(div_enable), 32'd0);
                end
                @(negedge clk);
                div_resp  = 1'b1;
                div_f     = ref_div(f3c, ac, bc);
                resp_edge = cyc + 1;
                @(negedge clk);
                div_resp = 1'b0;
                div_f    = '0;
            end
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        bit          spec;
        bit          hit;
        bit          use_div;
        bit          got;
        int          n_en;
        int          cnt;
        int          req_edge;
        exp     = ref_div(f3, a, b);
        spec    = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit     = !spec && cv && cf3 == f3 && ca == a && cb == b;
        use_div = !spec && !hit;
        @(negedge clk);
        req = 1'b1; req_funct3 = f3; req_a = a; req_b = b;
        req_edge = cyc + 1;
        n_en = 0; cnt = 0; got = 1'b0;
        while (!got && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (div_enable) begin
                n_en++;
                check("en_funct3", 32'(div_funct3), 32'(f3));
                check("en_a", div_a, a);
                check("en_b", div_b, b);
            end
            if (resp) got = 1'b1;
            else check("stall_high", 32'(stall), 32'd1);
        end
        check("resp_seen", 32'(got), 32'd1);
        if (got) begin
            check("result", result, exp);
            check("stall_at_resp", 32'(stall), 32'd0);
            check("enable_count", 32'(n_en), 32'(use_div));
            check("resp_latency", 32'(cyc), use_div ? 32'(resp_edge) : 32'(req_edge));
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check("resp_one_cycle", 32'(resp), 32'd0);
        if (use_div) begin
            cv = 1'b1; cf3 = f3; ca = a; cb = b;
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  pf3;
        logic [31:0] pa;
        logic [31:0] pb;
        int          w;
        rst = 1'b1; req = 1'b0; flush = 1'b0;
        req_funct3 = 3'b100; req_a = '0; req_b = '0;
        pf3 = 3'b100; pa = '0; pb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_enable", 32'(div_enable), 32'd0);
        check("rst_funct3", 32'(div_funct3), 32'd4);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        div_lat = 34;
        do_op(3'b101, 32'd100, 32'd7);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b100, 32'd5, 32'd0);
        do_op(3'b111, 32'd5, 32'd0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'b101, 32'd100, 32'd7);
        do_op(3'b101, 32'd100, 32'd7);

        @(negedge clk);
        rst = 1'b1;
        cv  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op(3'b101, 32'd100, 32'd7);

        // Flush ten cycles into the divide, then queue a new op behind the drain.
        @(negedge clk);
        req = 1'b1; req_funct3 = 3'b101; req_a = 32'd1000; req_b = 32'd3;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!div_enable && w < 50);
        check("flush_launch", 32'(div_enable), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        check("flush_no_resp", 32'(resp), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk); #1;
        check("drain_no_stall", 32'(stall), 32'd0);
        check("drain_no_resp", 32'(resp), 32'd0);
        do_op(3'b111, 32'd1000, 32'd3);

        for (int i = 0; i < 40; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                f3 = pf3; a = pa; b = pb;
            end else begin
                f3 = 3'(4 + $urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       a = 32'h8000_0000;
                    1:       a = $urandom_range(0, 50);
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 4))
                    0:       b = 32'd0;
                    1:       b = 32'hFFFF_FFFF;
                    2:       b = $urandom_range(1, 9);
                    default: b = $urandom;
                endcase
            end
            div_lat = $urandom_range(3, 40);
            do_op(f3, a, b);
            pf3 = f3; pa = a; pb = b;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
